// File: rtl/nonce_serializer.sv
// nonce_serializer: buffers whole words in a small FIFO and hands them out
// one byte at a time under consumer flow control (inc_data).
// Optional feature macro: NONCE_SER_CHECKSUM_EN -- when defined, each word is
// followed by one extra slot carrying the XOR of all its bytes.
module nonce_serializer #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    load,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    flush,
  input  logic                    inc_data,
  output logic                    valid_out,
  output logic [7:0]              read_data,
  output logic                    last_byte,
  output logic                    full,
  output logic                    overflow
);

`ifdef NONCE_SER_CHECKSUM_EN
  localparam int NSLOT = WORD_BYTES + 1;
`else
  localparam int NSLOT = WORD_BYTES;
`endif
  localparam int IDX_W = $clog2(NSLOT);
  localparam int SLOTS = 1 << IDX_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSLOT - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // Word storage; never reset, validity is tracked by count_reg alone.
  logic [8*WORD_BYTES-1:0] mem_reg [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             overflow_reg, overflow_next;

  logic                    push;
  logic                    advance;
  logic                    pop;
  logic [8*WORD_BYTES-1:0] head_word;
  logic [7:0]              slot_byte [SLOTS];

  assign full      = (count_reg == DEPTH_CNT);
  assign valid_out = (count_reg != '0);
  assign overflow  = overflow_reg;
  assign last_byte = valid_out && (idx_reg == LAST_IDX);

  // A load is dropped whenever the FIFO is full, even if the head pops now.
  assign push    = load && !full && !flush;
  assign advance = inc_data && valid_out && !flush;
  assign pop     = advance && (idx_reg == LAST_IDX);

  assign head_word = mem_reg[rd_ptr_reg];

`ifdef NONCE_SER_CHECKSUM_EN
  logic [7:0] checksum;

  // XOR of every byte of the head word, emitted in the extra final slot.
  always_comb begin
    checksum = 8'h00;
    for (int i = 0; i < WORD_BYTES; i++) begin
      checksum = checksum ^ head_word[8*i +: 8];
    end
  end
`endif

  // Map each slot index to the byte it presents; unused slots read as zero.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < WORD_BYTES) begin : g_data
        if (MSB_FIRST) begin : g_msb
          assign slot_byte[gi] = head_word[8*(WORD_BYTES-1-gi) +: 8];
        end else begin : g_lsb
          assign slot_byte[gi] = head_word[8*gi +: 8];
        end
      end
`ifdef NONCE_SER_CHECKSUM_EN
      else if (gi == WORD_BYTES) begin : g_cks
        assign slot_byte[gi] = checksum;
      end
`endif
      else begin : g_pad
        assign slot_byte[gi] = 8'h00;
      end
    end
  endgenerate

  assign read_data = valid_out ? slot_byte[idx_reg] : 8'h00;

  // Next-state: flush wins over everything, otherwise push/pop/advance.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    idx_next      = idx_reg;
    overflow_next = overflow_reg;
    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      idx_next      = '0;
      overflow_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if (advance) idx_next = pop ? '0 : idx_reg + 1'b1;
      if (load && full) overflow_next = 1'b1;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      idx_reg      <= idx_next;
      overflow_reg <= overflow_next;
    end
  end

  // Capture the word at acceptance; it is never touched again until popped.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= word_in;
  end

endmodule
